// File: rtl/jt51_slot_wr_sched.sv
// jt51_slot_wr_sched
//
// Write scheduler for the 32-slot time-multiplexed operator datapath.
// Host register writes are queued together with a target operator slot.
// Each write is released as a one-cycle strobe when the rotating slot
// position reaches its target slot. This lets every per-slot parameter
// memory be written in its own time slot.
//
// A 5-bit slot counter tracks the rotation. The frame sync `zero` realigns
// it, and a `zero` that arrives at a misaligned counter is flagged.
//
// Optional feature macro: JT51_SLOT_WR_MERGE_EN
//   When defined, a request whose slot equals the tail entry's slot
//   overwrites the tail data instead of allocating a new entry. A merge is
//   not done if the tail entry is leaving the queue in that same cycle.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cen          slot clock enable (one slot per cen cycle)
//   zero         frame sync; the cycle it is high is slot 0
//   req_valid    write request valid
//   req_ready    request can be accepted this cycle
//   req_slot     target slot of the request (0..31)
//   req_data     write data of the request
//   wr_en        registered one-cycle write strobe
//   wr_slot      slot of the last issued write (held between strobes)
//   wr_data      data of the last issued write (held between strobes)
//   synced       frame alignment established (sync FSM state == SYNC)
//   sync_err     one-cycle pulse after a zero seen at a misaligned counter
//
// Handshake: a request transfers in every cycle where req_valid and
// req_ready are both high. req_ready does not depend on req_valid. The
// requester keeps req_slot and req_data stable while req_valid is high
// and req_ready is low.

module jt51_slot_wr_sched #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          zero,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_slot,
    input  logic [DW-1:0] req_data,
    output logic          wr_en,
    output logic [4:0]    wr_slot,
    output logic [DW-1:0] wr_data,
    output logic          synced,
    output logic          sync_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNC   = 1'b1
    } state_t;

    state_t          state;
    logic [4:0]      cnt;
    logic [4:0]      cur;

    logic [4:0]      q_slot [DEPTH];
    logic [DW-1:0]   q_data [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   tail_ptr;
    logic [AW:0]     count;

    logic            full;
    logic            empty;
    logic            issue;
    logic            merge;
    logic            alloc;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign tail_ptr = wr_ptr - AW'(1);

    // A zero cycle is slot 0 even though cnt has not been reloaded yet.
    assign cur = zero ? 5'd0 : cnt;

    // The head entry issues only at its own slot, on a slot-advance cycle,
    // and only after frame alignment is known.
    assign issue = (state == ST_SYNC) && cen && !empty && (q_slot[rd_ptr] == cur);

`ifdef JT51_SLOT_WR_MERGE_EN
    logic merge_ok;

    // A single-entry queue whose entry is issuing has no tail to merge into.
    assign merge_ok  = !empty && (q_slot[tail_ptr] == req_slot) &&
                       !(issue && (count == (AW+1)'(1)));
    assign req_ready = !rst && (!full || merge_ok);
    assign merge     = req_valid && req_ready && merge_ok;
`else
    assign req_ready = !rst && !full;
    assign merge     = 1'b0;
`endif

    assign alloc  = req_valid && req_ready && !merge;
    assign synced = (state == ST_SYNC);

    // Control, slot counter, sync FSM and write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 5'd0;
            state    <= ST_UNSYNC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_en    <= 1'b0;
            wr_slot  <= 5'd0;
            wr_data  <= '0;
            sync_err <= 1'b0;
        end else begin
            // zero reloads to 1 because the zero cycle itself is slot 0.
            if (zero) begin
                cnt <= 5'd1;
            end else if (cen) begin
                cnt <= cnt + 5'd1;
            end

            case (state)
                ST_UNSYNC: begin
                    sync_err <= 1'b0;
                    if (zero) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    sync_err <= zero && (cnt != 5'd0);
                end
                default: begin
                    sync_err <= 1'b0;
                    state    <= ST_UNSYNC;
                end
            endcase

            wr_en <= issue;
            if (issue) begin
                wr_slot <= q_slot[rd_ptr];
                wr_data <= q_data[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end

            if (alloc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            case ({alloc, issue})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage. It needs no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (alloc) begin
            q_slot[wr_ptr] <= req_slot;
            q_data[wr_ptr] <= req_data;
        end else if (merge) begin
            q_data[tail_ptr] <= req_data;
        end
    end

endmodule

// File: doc/jt51_slot_wr_sched.md
# jt51_slot_wr_sched

Write scheduler for the 32-slot time-multiplexed operator datapath. It queues host register writes tagged with an operator slot number. Each write is released as a one-cycle strobe only when the rotating slot position reaches its target slot, so per-slot parameter memories are written in their own time slot. An internal 5-bit slot counter tracks the rotation; the frame-sync input `zero` keeps it aligned, and any misalignment is reported.

## Interface
- `DW`, default 8: write data width.
- `DEPTH`, default 4: queue depth in entries; power of two, at least 2.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cen` in 1: slot clock enable; one slot per `cen` cycle.
- `zero` in 1: frame sync; the cycle it is high is slot 0.
- `req_valid` in 1: write request valid.
- `req_ready` out 1: queue can accept; equals !full; 0 while `rst` is high.
- `req_slot` in 5: target slot, 0..31.
- `req_data` in DW: write data.
- `wr_en` out 1: registered one-cycle write strobe.
- `wr_slot` out 5: slot of the issued write; holds its value between strobes.
- `wr_data` out DW: data of the issued write; holds its value between strobes.
- `synced` out 1: high once frame alignment has been established.
- `sync_err` out 1: one-cycle pulse when `zero` arrives at a misaligned counter.

## Operation
- **Slot counter `cnt`** (5 bits):
  - if `zero`, `cnt` <= 1;
  - else if `cen`, `cnt` <= `cnt` + 1, wrapping 31 -> 0.
  - Current slot `cur` = `zero` ? 0 : `cnt`.
- **Sync FSM:**
  - UNSYNC -> SYNC on the first `zero`.
  - In SYNC, `zero` with `cnt` != 0 pulses `sync_err` the next cycle, reloads `cnt`, and stays in SYNC.
  - `synced` = (state == SYNC).
- **Queue:** FIFO of DEPTH entries of {slot, data}.
  - Push when `req_valid` && `req_ready`.
  - The queue accepts requests in both UNSYNC and SYNC.
- **Issue:** the head entry pops when all of these hold in the same cycle:
  - state == SYNC,
  - `cen`,
  - the queue is non-empty,
  - `cur` == head.slot.
- At most one issue per cycle. The head blocks later entries (strictly in order); a head waits up to 32 slots.
- **Simultaneous events:**
  - Push and pop in the same cycle: occupancy is unchanged.
  - A push into an empty queue cannot issue in that same cycle; the earliest issue is the next matching slot.
  - `zero` coinciding with an issue cycle: the match uses `cur` = 0.
- **Reset** (takes priority over everything):
  - `cnt` = 0, state = UNSYNC, queue empty;
  - `wr_en` = 0, `wr_slot` = 0, `wr_data` = 0, `sync_err` = 0, `synced` = 0.
  - Queued writes are discarded.

## Timing
- An issue decision in cycle N gives `wr_en` = 1, with `wr_slot`/`wr_data` updated, in cycle N+1, for exactly one cycle.
- `req_ready` is combinational from registered occupancy. A push in cycle N is visible as head/tail from N+1.
- `sync_err` is a registered pulse, one cycle after the offending `zero`.
- `synced` rises the cycle after the first `zero`.
- Throughput: at most one write per slot. Consecutive queue entries targeting consecutive slots issue on consecutive `cen` cycles.

## Configuration
- `JT51_SLOT_WR_MERGE_EN`
  - **Defined:** a request whose `req_slot` equals the tail entry's slot overwrites the tail data instead of allocating an entry. Merging happens only if the tail is not being popped that cycle. A merge is accepted even when the queue is full, so `req_ready` = !full || (`req_slot` == tail.slot && tail not popping).
  - **Undefined:** every accepted request allocates an entry; `req_ready` = !full.

## Test plan
- Reset, then `zero` pulse with `cen` always high; push {slot 5, 0xA5} -> `wr_en` high 1 cycle, 6 cycles after the `zero` cycle (issued at `cur` = 5, strobe the next cycle), with `wr_slot` = 5, `wr_data` = 0xA5.
- Push {3, 0x11} and {2, 0x22} before sync, then `zero` -> `synced` rises; 0x11 issues at slot 3; 0x22 waits for slot 2 of the next frame, 31 slots later.
- Fill DEPTH = 4 entries without `zero` -> `req_ready` = 0 and a 5th `req_valid` is not accepted; after sync and the first issue, `req_ready` = 1.
- `zero` at `cnt` = 17 while SYNC -> `sync_err` pulses once the next cycle, `cnt` = 1 after, pending writes issue on the realigned slots.
- `cen` low for 10 cycles at slot 8 with head slot 8 -> no `wr_en` until `cen` returns; then one strobe only.
- With `JT51_SLOT_WR_MERGE_EN`: push {7, 0x01} then {7, 0x02} -> a single `wr_en` with data 0x02. Without the macro: two strobes, 0x01 then 0x02, one frame apart.
